hw_divider: RTL and testbench
=============================

# hw_divider

Sequential restoring divider, one quotient bit per clock: 16-bit dividend by 8-bit divisor. It is the inverse-operation companion to the team's sequential shift-add multiplier. It uses the same start/done handshake, so the same bench style and chaining scheme (next start issued on the done rising edge) drive both blocks. A multiplier product can be fed straight back through it to recover the operands.

## Interface
- DW, 16: dividend and quotient width. Fixed; the bench assumes 16.
- VW, 8: divisor and remainder width. Fixed; the bench assumes 8.
- clk  in  1  rising-edge clock, sole clock domain
- rst_n  in  1  asynchronous active-low reset
- start  in  1  operation request, sampled on rising clk edge
- dividend  in  16  numerator, unsigned; sampled only with accepted start
- divisor  in  8  denominator, unsigned; sampled only with accepted start
- quotient  out  16  result quotient; registered, held until next completion
- remainder  out  8  result remainder; registered, held until next completion
- done  out  1  result valid; level, high from completion until next accepted start
- div_by_zero  out  1  last completed operation had divisor == 0; valid while done=1

## Operation
- States:
  - IDLE: reset state.
  - CALC: 16 iterations.
  - DONE: result held.
- Accept rule: start=1 at a clk edge while in IDLE or DONE.
  - Latches dividend into the shift register qs[15:0] and divisor into dv[7:0].
  - Clears pr[8:0], cnt[3:0], done and div_by_zero.
  - Next state: CALC, or the zero-divisor path below.
- start is ignored while in CALC; the operation in flight continues unaffected.
- CALC iteration, one per clk edge:
  - t = {pr[7:0], qs[15]}, 9 bits.
  - qs = {qs[14:0], t >= dv}.
  - pr = (t >= dv) ? t - dv : t.
  - The comparison is unsigned, 9-bit against zero-extended dv. pr never exceeds 2*dv-1, so it fits in 9 bits.
- After iteration cnt=15:
  - quotient <= final qs, remainder <= final pr[7:0].
  - done <= 1, state <= DONE.
- Zero divisor: accepted start with divisor == 0 skips CALC.
  - On the next edge: quotient <= 16'hFFFF, remainder <= dividend[7:0], div_by_zero <= 1, done <= 1, state DONE.
- quotient and remainder are separate output registers. They do not change during CALC and keep showing the previous result.
- DONE: outputs held; stays there until start. No auto-return to IDLE.
- Invariant for divisor != 0: dividend == quotient*divisor + remainder, and remainder < divisor.

## Timing
- Reset (async assert, any state, including mid-CALC):
  - state IDLE.
  - quotient = 0, remainder = 0, done = 0, div_by_zero = 0.
  - Internal qs/pr/cnt = 0.
  - Operation in flight is discarded.
- Reset release is synchronous to clk in effect: the first start is sampled at the first edge with rst_n=1.
- Start accepted at edge N: done drops after edge N.
- divisor != 0: done=1 after edge N+16 (16-cycle latency); quotient/remainder update at that same edge.
- divisor == 0: done=1 after edge N+1.
- Back-to-back operation:
  - The bench raises start one cycle after seeing the done rising edge; start at edge M re-enters CALC and done falls after M.
  - Throughput is 17 cycles per operation, including the accept cycle.
- start held high continuously: accepted at every IDLE/DONE edge. With divisor != 0, done is high for exactly one cycle per operation.
- Operands may change at any time except at the accepting edge; later changes have no effect.
- No combinational input-to-output paths.

## Test plan
- Reset, then 0x011E / 0x0B (286/11) -> after 16 cycles done=1, quotient=26 (0x001A), remainder=0, div_by_zero=0.
- 0xFFFF / 0xFF -> quotient=257 (0x0101), remainder=0; then 0xFFFF / 0x01 -> quotient=0xFFFF, remainder=0.
- 0x00FE / 0xFF -> quotient=0, remainder=254; then 0x1234 / 0x07 -> quotient=665 (0x0299), remainder=5.
- 1234 / 0 -> done after 1 cycle, div_by_zero=1, quotient=0xFFFF, remainder=0xD2; next op 100/3 -> div_by_zero=0, quotient=33, remainder=1.
- Start 0x8000 / 0x03. Pulse start with 0x0010/0x02 at cycle 5 of CALC -> ignored; result quotient=10922, remainder=2 at cycle 16. Prior outputs stay stable through CALC.
- Assert rst_n=0 at cycle 8 of a CALC -> all outputs 0 immediately. After release, 200/7 -> quotient=28, remainder=4.
- Soak: chain start on every done rising edge over a 10x10 operand sweep (step 0x1C), divisor != 0 -> invariant holds for every result, no timeouts.

Source files
------------

// File: rtl/hw_divider.sv
// Sequential restoring divider: 16-bit dividend by 8-bit divisor,
// one quotient bit per clock, start/done handshake.
module hw_divider #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          done,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] qs_q, qs_d;
  logic [VW-1:0] pr_q, pr_d;
  logic [VW-1:0] dv_q, dv_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          done_q, done_d;
  logic          dbz_q, dbz_d;

  logic [VW:0]   t;
  logic          ge;
  logic [VW-1:0] nxt_pr;
  logic [DW-1:0] nxt_qs;

  // Partial remainder stays below the divisor, so the low bits suffice.
  always_comb begin
    t      = {pr_q, qs_q[DW-1]};
    ge     = t >= {1'b0, dv_q};
    nxt_pr = ge ? (t[VW-1:0] - dv_q) : t[VW-1:0];
    nxt_qs = {qs_q[DW-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    qs_d    = qs_q;
    pr_d    = pr_q;
    dv_d    = dv_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    done_d  = done_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          qs_d    = dividend;
          dv_d    = divisor;
          pr_d    = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
          dbz_d   = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (dv_q == '0) begin
          quo_d   = '1;
          rem_d   = qs_q[VW-1:0];
          dbz_d   = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          qs_d  = nxt_qs;
          pr_d  = nxt_pr;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            quo_d   = nxt_qs;
            rem_d   = nxt_pr;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      qs_q    <= '0;
      pr_q    <= '0;
      dv_q    <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      qs_q    <= qs_d;
      pr_q    <= pr_d;
      dv_q    <= dv_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_hw_divider.sv
// Directed self-checking bench for hw_divider.
// Inputs change 1 time unit after a rising edge; outputs sampled there too.
module tb_hw_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        done;
  logic        div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  hw_divider dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, wait for done (bounded); cyc = edges after accept.
  task automatic do_op(input logic [15:0] dd, input logic [7:0] dv,
                       output int cyc);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    dividend = 16'hA5A5;
    divisor  = 8'h5A;
    cyc = 0;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({quotient, remainder, done, div_by_zero} !== 26'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got q=%h r=%h d=%b z=%b want all 0",
               quotient, remainder, done, div_by_zero);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int cyc;
    do_op(16'h011E, 8'h0B, cyc);
    n_cmp++;
    if (cyc !== 16) begin
      n_bad++;
      $display("FAIL basic_latency got %0d want 16", cyc);
    end
    n_cmp++;
    if ({quotient, remainder, div_by_zero} !== {16'd26, 8'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL basic_286_11 got q=%0d r=%0d z=%b want 26 0 0",
               quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_extremes();
    int cyc;
    do_op(16'hFFFF, 8'hFF, cyc);
    n_cmp++;
    if (cyc !== 16 || quotient !== 16'h0101 || remainder !== 8'd0) begin
      n_bad++;
      $display("FAIL ffff_ff got c=%0d q=%h r=%h want 16 0101 00",
               cyc, quotient, remainder);
    end
    do_op(16'hFFFF, 8'h01, cyc);
    n_cmp++;
    if (cyc !== 16 || quotient !== 16'hFFFF || remainder !== 8'd0) begin
      n_bad++;
      $display("FAIL ffff_01 got c=%0d q=%h r=%h want 16 ffff 00",
               cyc, quotient, remainder);
    end
    do_op(16'h00FE, 8'hFF, cyc);
    n_cmp++;
    if (cyc !== 16 || quotient !== 16'd0 || remainder !== 8'd254) begin
      n_bad++;
      $display("FAIL 00fe_ff got c=%0d q=%0d r=%0d want 16 0 254",
               cyc, quotient, remainder);
    end
    do_op(16'h1234, 8'h07, cyc);
    n_cmp++;
    if (cyc !== 16 || quotient !== 16'd665 || remainder !== 8'd5) begin
      n_bad++;
      $display("FAIL 1234_07 got c=%0d q=%0d r=%0d want 16 665 5",
               cyc, quotient, remainder);
    end
  endtask

  task automatic test_zero();
    int cyc;
    do_op(16'd1234, 8'd0, cyc);
    n_cmp++;
    if (cyc !== 1) begin
      n_bad++;
      $display("FAIL zero_latency got %0d want 1", cyc);
    end
    n_cmp++;
    if ({quotient, remainder, div_by_zero} !== {16'hFFFF, 8'hD2, 1'b1}) begin
      n_bad++;
      $display("FAIL zero_result got q=%h r=%h z=%b want ffff d2 1",
               quotient, remainder, div_by_zero);
    end
    do_op(16'd100, 8'd3, cyc);
    n_cmp++;
    if (cyc !== 16 || {quotient, remainder, div_by_zero}
        !== {16'd33, 8'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL after_zero got c=%0d q=%0d r=%0d z=%b want 16 33 1 0",
               cyc, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_ignore_start();
    int cyc;
    int unstable;
    unstable = 0;
    dividend = 16'h8000;
    divisor  = 8'h03;
    start    = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 40) begin
      if (quotient !== 16'd33 || remainder !== 8'd1) unstable++;
      if (cyc == 4) begin
        dividend = 16'h0010;
        divisor  = 8'h02;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    n_cmp++;
    if (unstable !== 0) begin
      n_bad++;
      $display("FAIL calc_hold got %0d changed cycles want 0", unstable);
    end
    n_cmp++;
    if (cyc !== 16 || quotient !== 16'd10922 || remainder !== 8'd2) begin
      n_bad++;
      $display("FAIL ignore_start got c=%0d q=%0d r=%0d want 16 10922 2",
               cyc, quotient, remainder);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    dividend = 16'h8000;
    divisor  = 8'h03;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({quotient, remainder, done, div_by_zero} !== 26'd0) begin
      n_bad++;
      $display("FAIL mid_reset got q=%h r=%h d=%b z=%b want all 0",
               quotient, remainder, done, div_by_zero);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_op(16'd200, 8'd7, cyc);
    n_cmp++;
    if (cyc !== 16 || quotient !== 16'd28 || remainder !== 8'd4) begin
      n_bad++;
      $display("FAIL post_reset got c=%0d q=%0d r=%0d want 16 28 4",
               cyc, quotient, remainder);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [15:0] dd;
    logic [7:0]  dv;
    logic [23:0] recon;
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 10; j++) begin
        dd = 16'(i * 16'h1C * 233 + j * 16'h1C);
        dv = 8'(j * 8'h1C + 3);
        do_op(dd, dv, cyc);
        recon = 24'(quotient) * 24'(dv) + 24'(remainder);
        n_cmp++;
        if (cyc !== 16 || recon !== 24'(dd) || remainder >= dv
            || quotient !== dd / 16'(dv)) begin
          n_bad++;
          $display("FAIL soak %h/%h got c=%0d q=%h r=%h want 16 %h %h",
                   dd, dv, cyc, quotient, remainder,
                   dd / 16'(dv), dd % 16'(dv));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
